button_conditioner: RTL and testbench

//  Conditions raw asynchronous board push-buttons into clean, clk-domain control for the CPU top.
//  Per channel: 2-FF synchroniser, debounce FSM, one-cycle press/release pulses, level and toggle.

---
 rtl/button_conditioner.sv | 165 ++++++++++++++++
 tb/tb_button_conditioner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: per channel 2-FF synchroniser, debounce FSM, press/release pulses,
// level and toggle. Define LONG_PRESS_EN to add the long-press pulse (tied to 0 otherwise).
//
// state          | meaning
// S_RELEASED     | button accepted as not pressed
// S_PRESS_WAIT   | pressed seen, counting stable cycles before accepting
// S_PRESSED      | button accepted as pressed
// S_RELEASE_WAIT | release seen, counting stable cycles before accepting
module button_conditioner #(
   parameter int N_BTN           = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ACTIVE_LOW_IN   = 1'b1,
   parameter int LONG_CYCLES     = 50000000
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw_i,
   output logic [N_BTN-1:0] level_o,
   output logic [N_BTN-1:0] press_o,
   output logic [N_BTN-1:0] release_o,
   output logic [N_BTN-1:0] toggle_o,
   output logic [N_BTN-1:0] long_press_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RELEASED,
      S_PRESS_WAIT,
      S_PRESSED,
      S_RELEASE_WAIT
   } state_t;

   if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
      $error("DEBOUNCE_CYCLES must be at least 1");
   end
   if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_chk_long
      $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
   end

   logic [N_BTN-1:0] in_pressed;
   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] sync2_q;

   // Polarity is normalised before the synchroniser so reset means "not pressed".
   assign in_pressed = btn_raw_i ^ {N_BTN{ACTIVE_LOW_IN}};

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= in_pressed;
         sync2_q <= sync1_q;
      end
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      state_t        state_q;
      logic [CW-1:0] cnt_q;
      logic          level_q;
      logic          press_q;
      logic          release_q;
      logic          toggle_q;
      logic          s;

      assign s = sync2_q[g];

      always_ff @(posedge clk_i or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= S_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
         end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
               S_RELEASED: begin
                  if (s) begin
                     state_q <= S_PRESS_WAIT;
                     cnt_q   <= '0;
                  end
               end
               S_PRESS_WAIT: begin
                  if (!s) begin
                     state_q <= S_RELEASED;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q  <= S_PRESSED;
                     cnt_q    <= '0;
                     level_q  <= 1'b1;
                     press_q  <= 1'b1;
                     toggle_q <= ~toggle_q;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               S_PRESSED: begin
                  if (!s) begin
                     state_q <= S_RELEASE_WAIT;
                     cnt_q   <= '0;
                  end
               end
               S_RELEASE_WAIT: begin
                  if (s) begin
                     state_q <= S_PRESSED;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q   <= S_RELEASED;
                     cnt_q     <= '0;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: begin
                  state_q <= S_RELEASED;
                  cnt_q   <= '0;
               end
            endcase
         end
      end

      assign level_o[g]   = level_q;
      assign press_o[g]   = press_q;
      assign release_o[g] = release_q;
      assign toggle_o[g]  = toggle_q;

`ifdef LONG_PRESS_EN
      localparam int HW = $clog2(LONG_CYCLES + 1);
      localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

      logic [HW-1:0] hcnt_q;
      logic          long_q;

      // hcnt saturates at HOLD_LAST, so the pulse cannot repeat until hcnt is cleared in RELEASED.
      always_ff @(posedge clk_i or negedge rst_n) begin
         if (!rst_n) begin
            hcnt_q <= '0;
            long_q <= 1'b0;
         end else begin
            long_q <= 1'b0;
            if (state_q == S_PRESSED || state_q == S_RELEASE_WAIT) begin
               if (hcnt_q != HOLD_LAST) begin
                  hcnt_q <= hcnt_q + HW'(1);
                  if (hcnt_q == HOLD_LAST - HW'(1)) long_q <= 1'b1;
               end
            end else begin
               hcnt_q <= '0;
            end
         end
      end

      assign long_press_o[g] = long_q;
`else
      assign long_press_o[g] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised scoreboard bench for button_conditioner; the reference model works on run lengths of
// the observed pressed state rather than on FSM states.
module tb_button_conditioner;

   localparam int N   = 2;
   localparam int DEB = 4;
   localparam int LNG = 20;
   localparam bit AL  = 1'b1;

   logic         clk_i = 1'b0;
   logic         rst_n;
   logic [N-1:0] btn_raw_i;
   logic [N-1:0] level_o, press_o, release_o, toggle_o, long_press_o;

   button_conditioner #(
      .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW_IN(AL), .LONG_CYCLES(LNG)
   ) dut (
      .clk_i(clk_i), .rst_n(rst_n), .btn_raw_i(btn_raw_i),
      .level_o(level_o), .press_o(press_o), .release_o(release_o),
      .toggle_o(toggle_o), .long_press_o(long_press_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [N-1:0] lvl;
      logic [N-1:0] prs;
      logic [N-1:0] rel;
      logic [N-1:0] tgl;
      logic [N-1:0] lp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_no = 0;

   // Reference state: pressed samples seen 1 and 2 edges ago, accepted level, toggle,
   // length of the current run of observations disagreeing with the level, edges held.
   bit   hist0[N], hist1[N];
   bit   lvl_m[N], tgl_m[N];
   int   run_m[N], held_m[N];

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         hist0[c] = 0; hist1[c] = 0; lvl_m[c] = 0; tgl_m[c] = 0;
         run_m[c] = 0; held_m[c] = 0;
      end
   endtask

   task automatic model_step();
      exp_t         e;
      logic [N-1:0] pressed_now;
      bit           obs, was_lvl;
      e = '0;
      edge_no++;
      if (!rst_n) begin
         model_reset();
      end else begin
         pressed_now = btn_raw_i ^ {N{AL}};
         for (int c = 0; c < N; c++) begin
            obs       = hist1[c];
            hist1[c]  = hist0[c];
            hist0[c]  = pressed_now[c];
            was_lvl   = lvl_m[c];
            if (was_lvl) begin
               held_m[c]++;
`ifdef LONG_PRESS_EN
               if (held_m[c] == LNG - 1) e.lp[c] = 1'b1;
`endif
            end
            // A new value is accepted after DEB+1 consecutive disagreeing observations.
            if (obs != lvl_m[c]) begin
               run_m[c]++;
               if (run_m[c] == DEB + 1) begin
                  lvl_m[c]  = obs;
                  run_m[c]  = 0;
                  held_m[c] = 0;
                  if (obs) begin
                     e.prs[c] = 1'b1;
                     tgl_m[c] = ~tgl_m[c];
                  end else begin
                     e.rel[c] = 1'b1;
                  end
               end
            end else begin
               run_m[c] = 0;
            end
            e.lvl[c] = lvl_m[c];
            e.tgl[c] = tgl_m[c];
         end
      end
      sb.push_back(e);
   endtask

   task automatic tick(input logic [N-1:0] pressed, input logic rst_v);
      @(negedge clk_i);
      #1;
      rst_n     = rst_v;
      btn_raw_i = pressed ^ {N{AL}};
      @(posedge clk_i);
      model_step();
   endtask

   task automatic hold(input logic [N-1:0] pressed, input int cycles);
      for (int i = 0; i < cycles; i++) tick(pressed, 1'b1);
   endtask

   initial begin : monitor
      exp_t e, got;
      forever begin
         @(negedge clk_i);
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {level_o, press_o, release_o, toggle_o, long_press_o};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL outputs edge %0d: got lvl=%b prs=%b rel=%b tgl=%b lp=%b want lvl=%b prs=%b rel=%b tgl=%b lp=%b",
                        edge_no, got.lvl, got.prs, got.rel, got.tgl, got.lp,
                        e.lvl, e.prs, e.rel, e.tgl, e.lp);
            end
         end
      end
   end

   initial begin : stim
      logic [N-1:0] pat;
      rst_n     = 1'b0;
      btn_raw_i = {N{AL}};
      model_reset();

      for (int i = 0; i < 3; i++) tick('0, 1'b0);
      hold('0, 3);
      // clean press and release on ch0
      hold(2'b01, 12);
      hold(2'b00, 10);
      // bounce shorter than the debounce window
      hold(2'b01, 3); hold(2'b00, 1); hold(2'b01, 3); hold(2'b00, 8);
      // two presses on ch1
      hold(2'b10, 10); hold(2'b00, 10);
      hold(2'b10, 10); hold(2'b00, 10);
      // simultaneous presses
      hold(2'b11, 10); hold(2'b00, 10);
      // long hold with a release bounce inside
      hold(2'b01, 30); hold(2'b00, 2); hold(2'b01, 10); hold(2'b00, 10);
      // reset in the middle of PRESS_WAIT with the button still held
      hold(2'b01, 4);
      tick(2'b01, 1'b0); tick(2'b01, 1'b0);
      hold(2'b01, 12);
      hold(2'b00, 10);

      for (int seg = 0; seg < 400; seg++) begin
         pat = N'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            for (int i = 0; i < int'($urandom_range(1, 2)); i++) tick(pat, 1'b0);
         end else if ($urandom_range(0, 3) == 0) begin
            hold(pat, $urandom_range(15, 30));
         end else begin
            hold(pat, $urandom_range(1, 8));
         end
      end
      hold('0, 12);

      @(negedge clk_i);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
